pulse_burst_sequencer: RTL and testbench
========================================

# pulse_burst_sequencer

Bus-master controller that drives the pulse/counter control register block over its register port. On a single start command it optionally clears the counter and the sticky overflow flag, issues a programmed number of pulse-enable writes with a fixed gap between them, then reads back count and overflow and reports them with a one-cycle done strobe. It sits between the host control logic and the register block, which it owns exclusively while busy.

## Interface
- `BURST_W`, 8: width of `burst_len` and the internal remaining-pulse counter.
- `GAP_CYCLES`, 2: idle bus cycles after every pulse write; legal range 1..15 (elaboration error outside).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset: one clock, synchronous, active-high (polarity and synchronicity fixed).
- `start`  in  1  begin a burst; sampled only in IDLE.
- `burst_len`  in  BURST_W  pulses to issue; latched with `start`.
- `clr_first`  in  1  clear counter and overflow before pulsing; latched with `start`.
- `abort`  in  1  stop the current burst at the next state boundary.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle strobe at end of burst or abort.
- `aborted`  out  1  valid with `done`: 1 if the burst was aborted.
- `final_count`  out  3  count read back in STATUS; held until next STATUS.
- `overflow_seen`  out  1  sticky overflow read back in STATUS; held until next STATUS.
- `reg_wr_en`, `reg_rd_en`  out  1  register-port strobes, never both high.
- `reg_addr`  out  10  0x000 CTRL or 0x004 STATUS.
- `reg_wdata`  out  32  write data.
- `reg_rdata`  in  32  combinational read data from the register block.

## Operation
- Target map: CTRL 0x000 (bit0 pulse_en, bit1 count_clr level); STATUS 0x004 (bits[2:0] count, bit3 overflow sticky; write with bit3=0 clears sticky).
- States: IDLE, CLR_SET, CLR_REL, OVF_CLR, PULSE, GAP, STATUS, ABORT, DONE.
- IDLE: bus idle (all strobes 0, addr/wdata 0). On `start`: latch `burst_len`, `clr_first`; zero `aborted`. `burst_len`=0 -> DONE; `clr_first`=1 -> CLR_SET; else PULSE.
- CLR_SET: write CTRL=0x2 -> CLR_REL: write CTRL=0x0 -> OVF_CLR: write STATUS=0x0 -> PULSE.
- PULSE: write CTRL=0x1; remaining -= 1 -> GAP.
- GAP: bus idle for exactly GAP_CYCLES cycles (4-bit timer); then remaining>0 -> PULSE, else -> STATUS.
- STATUS: read STATUS; at the clock edge capture `final_count`=rdata[2:0], `overflow_seen`=rdata[3] -> DONE.
- DONE: `done`=1 for one cycle -> IDLE.
- `abort` is sampled in CLR_SET..GAP: the next state becomes ABORT instead of the normal successor (the current-cycle write still completes). ABORT: write CTRL=0x0 (drops count_clr), set `aborted` -> DONE. `final_count`/`overflow_seen` are not updated on abort. `abort` in IDLE, STATUS, ABORT or DONE is ignored.
- `start` while busy is ignored; it is not queued.
- Bus outputs are a pure decode of the registered state (Moore); no bus access in a reset cycle.

## Timing
- Reset: state IDLE; `busy`, `done`, `aborted`, `final_count`, `overflow_seen`, all `reg_*` outputs 0; remaining and gap timer 0.
- `busy` rises the cycle after `start` is sampled.
- With clr_first=0, N>0, G=GAP_CYCLES, `start` sampled at edge 0: pulse writes at cycles 1+k(G+1), k=0..N-1; STATUS at 1+N(G+1); `done` at 2+N(G+1); IDLE, and a new `start` accepted, at 3+N(G+1).
- clr_first=1 adds 3 cycles before the first pulse.
- N=0: `done` at cycle 1 with no bus access; outputs held.
- Back-to-back: `start` high in the cycle after `done` starts a new burst.
- Reset mid-burst returns to IDLE next edge with no `done` and no cleanup write. CTRL count_clr may remain set in the target until the next burst with clr_first=1.

## Structure
- Shared package `pulse_ctrl_pkg`: CTRL/STATUS address constants, bit indices (PULSE_EN=0, COUNT_CLR=1, OVF=3, COUNT msb/lsb), and the state enum.
- Single module; the gap timer and remaining counter are inline, and no sub-module is warranted.

## Test plan
- Bench: sequencer + register block + 3-bit wrapping counter that asserts overflow on the 7->0 wrap.
- clr_first=1, burst_len=5, G=2 -> writes 0x2, 0x0, STATUS 0x0, then 5 CTRL=0x1 writes 3 cycles apart; final_count=5, overflow_seen=0, done once, aborted=0.
- clr_first=1, burst_len=10 -> final_count=2, overflow_seen=1; a second burst with clr_first=1 and burst_len=1 -> final_count=1, overflow_seen=0.
- burst_len=0 -> done at cycle 1 with zero bus strobes; final_count and overflow_seen unchanged.
- abort asserted in the 3rd GAP of a burst_len=6 -> CTRL=0x0 write, then done with aborted=1; exactly 3 pulses seen; outputs unchanged.
- rst pulsed during PULSE -> all outputs 0 next cycle, no done; start ignored while busy; back-to-back start the cycle after done is accepted.

Source files
------------

// File: rtl/pulse_ctrl_pkg.sv
// Shared definitions for the pulse/counter control register block and the
// sequencer that drives it: register addresses, bit positions and FSM states.
package pulse_ctrl_pkg;

    localparam logic [9:0] CTRL_ADDR   = 10'h000;
    localparam logic [9:0] STATUS_ADDR = 10'h004;

    localparam int PULSE_EN_BIT  = 0;
    localparam int COUNT_CLR_BIT = 1;
    localparam int OVF_BIT       = 3;
    localparam int COUNT_MSB     = 2;
    localparam int COUNT_LSB     = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR_SET,
        ST_CLR_REL,
        ST_OVF_CLR,
        ST_PULSE,
        ST_GAP,
        ST_STATUS,
        ST_ABORT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pulse_burst_sequencer.sv
// Bus master that optionally clears the pulse counter, issues a burst of
// pulse-enable writes separated by a fixed idle gap, then reads back status.
module pulse_burst_sequencer
    import pulse_ctrl_pkg::*;
#(
    parameter int BURST_W    = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               clr_first,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [2:0]         final_count,
    output logic               overflow_seen,
    output logic               reg_wr_en,
    output logic               reg_rd_en,
    output logic [9:0]         reg_addr,
    output logic [31:0]        reg_wdata,
    input  logic [31:0]        reg_rdata
);

    generate
        if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
            $error("pulse_burst_sequencer: GAP_CYCLES must be in 1..15");
        end
    endgenerate

    // Timer counts down to zero, so loading G-1 yields exactly G idle cycles.
    localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);

    state_e             state_q, state_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic [3:0]         gap_q, gap_d;
    logic               aborted_q, aborted_d;
    logic [2:0]         final_count_q, final_count_d;
    logic               overflow_q, overflow_d;
    logic               abortable;

    // Only the low status bits carry information.
    logic unused_rdata;
    assign unused_rdata = &{1'b0, reg_rdata[31:4]};

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        gap_d         = gap_q;
        aborted_d     = aborted_q;
        final_count_d = final_count_q;
        overflow_d    = overflow_q;
        abortable     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = burst_len;
                    aborted_d   = 1'b0;
                    if (burst_len == '0) begin
                        state_d = ST_DONE;
                    end else if (clr_first) begin
                        state_d = ST_CLR_SET;
                    end else begin
                        state_d = ST_PULSE;
                    end
                end
            end
            ST_CLR_SET: begin
                abortable = 1'b1;
                state_d   = ST_CLR_REL;
            end
            ST_CLR_REL: begin
                abortable = 1'b1;
                state_d   = ST_OVF_CLR;
            end
            ST_OVF_CLR: begin
                abortable = 1'b1;
                state_d   = ST_PULSE;
            end
            ST_PULSE: begin
                abortable   = 1'b1;
                remaining_d = remaining_q - 1'b1;
                gap_d       = GAP_INIT;
                state_d     = ST_GAP;
            end
            ST_GAP: begin
                abortable = 1'b1;
                if (gap_q == 4'd0) begin
                    state_d = (remaining_q != '0) ? ST_PULSE : ST_STATUS;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            ST_STATUS: begin
                final_count_d = reg_rdata[COUNT_MSB:COUNT_LSB];
                overflow_d    = reg_rdata[OVF_BIT];
                state_d       = ST_DONE;
            end
            ST_ABORT: begin
                aborted_d = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abortable && abort) begin
            state_d = ST_ABORT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            gap_q         <= 4'd0;
            aborted_q     <= 1'b0;
            final_count_q <= 3'd0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            gap_q         <= gap_d;
            aborted_q     <= aborted_d;
            final_count_q <= final_count_d;
            overflow_q    <= overflow_d;
        end
    end

    // Bus port is a pure decode of the registered state.
    always_comb begin
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        reg_addr  = 10'h000;
        reg_wdata = 32'h0;
        case (state_q)
            ST_CLR_SET: begin
                reg_wr_en                = 1'b1;
                reg_addr                 = CTRL_ADDR;
                reg_wdata[COUNT_CLR_BIT] = 1'b1;
            end
            ST_CLR_REL, ST_ABORT: begin
                reg_wr_en = 1'b1;
                reg_addr  = CTRL_ADDR;
            end
            ST_OVF_CLR: begin
                reg_wr_en = 1'b1;
                reg_addr  = STATUS_ADDR;
            end
            ST_PULSE: begin
                reg_wr_en               = 1'b1;
                reg_addr                = CTRL_ADDR;
                reg_wdata[PULSE_EN_BIT] = 1'b1;
            end
            ST_STATUS: begin
                reg_rd_en = 1'b1;
                reg_addr  = STATUS_ADDR;
            end
            default: begin
                reg_wr_en = 1'b0;
            end
        endcase
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign aborted       = aborted_q;
    assign final_count   = final_count_q;
    assign overflow_seen = overflow_q;

endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// Directed bench: sequencer driving a behavioural CTRL/STATUS block with a
// 3-bit wrapping pulse counter and sticky overflow.
module tb_pulse_burst_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  burst_len;
    logic        clr_first;
    logic        abort;
    logic        busy, done, aborted, overflow_seen;
    logic [2:0]  final_count;
    logic        reg_wr_en, reg_rd_en;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;

    int checks = 0;
    int errors = 0;

    pulse_burst_sequencer #(.BURST_W(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .clr_first(clr_first), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .final_count(final_count), .overflow_seen(overflow_seen),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    // Target register block model
    logic [1:0] t_ctrl = 2'b00;
    logic [2:0] t_cnt  = 3'd0;
    logic       t_ovf  = 1'b0;

    assign reg_rdata = (reg_addr == 10'h004) ? {28'd0, t_ovf, t_cnt} : {30'd0, t_ctrl};

    always @(posedge clk) begin
        if (reg_wr_en && reg_addr == 10'h000) begin
            t_ctrl <= reg_wdata[1:0];
            if (reg_wdata[1]) begin
                t_cnt <= 3'd0;
            end else if (reg_wdata[0]) begin
                t_cnt <= t_cnt + 3'd1;
                if (t_cnt == 3'd7) t_ovf <= 1'b1;
            end
        end else if (t_ctrl[1]) begin
            t_cnt <= 3'd0;
        end
        if (reg_wr_en && reg_addr == 10'h004 && !reg_wdata[3]) t_ovf <= 1'b0;
    end

    // Bus monitor
    int          cyc_q = 0;
    logic [41:0] wlog[$];
    int          wcyc[$];
    int          pulse_cnt = 0, done_cnt = 0, strobe_cnt = 0;

    always @(posedge clk) begin
        cyc_q++;
        if (reg_wr_en) begin
            wlog.push_back({reg_addr, reg_wdata});
            wcyc.push_back(cyc_q);
        end
        if (reg_wr_en || reg_rd_en) strobe_cnt++;
        if (reg_wr_en && reg_addr == 10'h000 && reg_wdata[0]) pulse_cnt++;
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in cycle 1 of the burst (start sampled at edge 0).
    task automatic start_burst(input logic [7:0] len, input logic clr);
        start     = 1'b1;
        burst_len = len;
        clr_first = clr;
        step();
        start     = 1'b0;
        burst_len = 8'd0;
        clr_first = 1'b0;
    endtask

    task automatic wait_done(input int from_cyc, input int max_cyc, output int cyc);
        cyc = from_cyc;
        while (done !== 1'b1 && cyc < max_cyc) begin
            step();
            cyc++;
        end
        if (done !== 1'b1) check("done_timeout", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int c, wb, db, pb, sb;

        rst = 1'b1; start = 1'b0; burst_len = 8'd0; clr_first = 1'b0; abort = 1'b0;
        step();
        step();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_aborted", {63'd0, aborted}, 64'd0);
        check("rst_final", {61'd0, final_count}, 64'd0);
        check("rst_ovf", {63'd0, overflow_seen}, 64'd0);
        check("rst_wr", {63'd0, reg_wr_en}, 64'd0);
        check("rst_rd", {63'd0, reg_rd_en}, 64'd0);
        check("rst_addr", {54'd0, reg_addr}, 64'd0);
        check("rst_wdata", {32'd0, reg_wdata}, 64'd0);
        rst = 1'b0;
        step();

        // A: clr_first, 5 pulses
        wb = wlog.size(); db = done_cnt;
        start_burst(8'd5, 1'b1);
        check("A_busy_rise", {63'd0, busy}, 64'd1);
        wait_done(1, 100, c);
        check("A_done_cycle", c, 20);
        check("A_wr_count", wlog.size() - wb, 8);
        check("A_w0_clrset", {22'd0, wlog[wb+0]}, {22'd0, 10'h000, 32'h2});
        check("A_w1_clrrel", {22'd0, wlog[wb+1]}, {22'd0, 10'h000, 32'h0});
        check("A_w2_ovfclr", {22'd0, wlog[wb+2]}, {22'd0, 10'h004, 32'h0});
        for (int k = 3; k < 8; k++) begin
            check("A_pulse_wr", {22'd0, wlog[wb+k]}, {22'd0, 10'h000, 32'h1});
        end
        check("A_pulse_gap", wcyc[wb+4] - wcyc[wb+3], 3);
        check("A_final", {61'd0, final_count}, 64'd5);
        check("A_ovf", {63'd0, overflow_seen}, 64'd0);
        check("A_aborted", {63'd0, aborted}, 64'd0);
        step();
        check("A_done_once", done_cnt - db, 1);
        check("A_idle", {62'd0, busy, done}, 64'd0);
        $display("burst A len=5 clr=1 done@%0d count=%0d ovf=%0d", c, final_count, overflow_seen);

        // B: wrap to overflow, then back-to-back clear burst
        start_burst(8'd10, 1'b1);
        wait_done(1, 200, c);
        check("B_done_cycle", c, 35);
        check("B_final", {61'd0, final_count}, 64'd2);
        check("B_ovf", {63'd0, overflow_seen}, 64'd1);
        $display("burst B len=10 clr=1 done@%0d count=%0d ovf=%0d", c, final_count, overflow_seen);
        step();
        start_burst(8'd1, 1'b1);
        check("B2_back_to_back", {63'd0, busy}, 64'd1);
        wait_done(1, 100, c);
        check("B2_done_cycle", c, 8);
        check("B2_final", {61'd0, final_count}, 64'd1);
        check("B2_ovf", {63'd0, overflow_seen}, 64'd0);
        $display("burst B2 len=1 clr=1 done@%0d count=%0d ovf=%0d", c, final_count, overflow_seen);
        step();

        // C: zero-length burst
        sb = strobe_cnt;
        start_burst(8'd0, 1'b1);
        check("C_done_c1", {63'd0, done}, 64'd1);
        check("C_strobes", strobe_cnt - sb, 0);
        check("C_final_held", {61'd0, final_count}, 64'd1);
        check("C_ovf_held", {63'd0, overflow_seen}, 64'd0);
        $display("burst C len=0 done@1 count=%0d ovf=%0d", final_count, overflow_seen);
        step();

        // D: abort in third GAP of a 6-pulse burst
        pb = pulse_cnt;
        start_burst(8'd6, 1'b0);
        for (int k = 0; k < 7; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("D_abort_wr", {21'd0, reg_wr_en, reg_addr, reg_wdata}, {21'd0, 1'b1, 10'h000, 32'h0});
        step();
        check("D_done", {63'd0, done}, 64'd1);
        check("D_aborted", {63'd0, aborted}, 64'd1);
        check("D_pulses", pulse_cnt - pb, 3);
        check("D_final_held", {61'd0, final_count}, 64'd1);
        check("D_target_cnt", {61'd0, t_cnt}, 64'd4);
        $display("burst D len=6 aborted=%0d pulses=%0d", aborted, pulse_cnt - pb);
        step();

        // E: start while busy is ignored
        pb = pulse_cnt;
        start_burst(8'd2, 1'b0);
        step();
        start = 1'b1; burst_len = 8'd7;
        step();
        start = 1'b0; burst_len = 8'd0;
        wait_done(3, 100, c);
        check("E_done_cycle", c, 8);
        check("E_pulses", pulse_cnt - pb, 2);
        check("E_final", {61'd0, final_count}, 64'd6);
        check("E_aborted_clr", {63'd0, aborted}, 64'd0);
        $display("burst E len=2 done@%0d count=%0d", c, final_count);
        step();

        // F: reset during PULSE
        start_burst(8'd4, 1'b0);
        check("F_in_pulse", {63'd0, reg_wr_en}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("F_rst_outs", {53'd0, busy, done, aborted, final_count, overflow_seen, reg_wr_en, reg_rd_en},
              64'd0);
        check("F_rst_bus", {22'd0, reg_addr, reg_wdata}, 64'd0);
        db = done_cnt; sb = strobe_cnt;
        for (int k = 0; k < 10; k++) step();
        check("F_no_done", done_cnt - db, 0);
        check("F_no_bus", strobe_cnt - sb, 0);
        $display("burst F reset mid-burst busy=%0d", busy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
